// File: rtl/stereo_serial_tx.sv
// Stereo output serializer: one holding register pair feeding a lockstep
// MSB-first shifter, with per-word OutFrame marking and an optional inter-word gap.
module stereo_serial_tx #(
  parameter int unsigned DATA_W     = 40,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic              Sclk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] DataInL,
  input  logic [DATA_W-1:0] DataInR,
  input  logic              DataValid,
  output logic              DataAccept,
  output logic              OutputL,
  output logic              OutputR,
  output logic              OutReady,
  output logic              OutFrame,
  output logic              Busy,
  output logic              Underrun
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_hold_full;
  logic [DATA_W-1:0] r_hold_l;
  logic [DATA_W-1:0] r_hold_r;
  logic [DATA_W-1:0] r_shift_l;
  logic [DATA_W-1:0] r_shift_r;
  logic [CNT_W-1:0]  r_cnt;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic              w_load;
  logic              w_shift;
  logic              w_underrun;
  logic              w_gap_start;

  assign DataAccept = !r_hold_full;
  assign Busy       = r_hold_full || (r_state != S_IDLE);

  always_ff @(posedge Sclk) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    w_underrun   = 1'b0;
    w_gap_start  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_hold_full) begin
          w_load       = 1'b1;
          w_state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_cnt != '0) begin
          w_shift = 1'b1;
        end else begin
          // Underrun flags a word ending with nothing held, gap or not.
          w_underrun = !r_hold_full;
          if (GAP_CYCLES != 0) begin
            w_gap_start  = 1'b1;
            w_state_next = S_GAP;
          end else if (r_hold_full) begin
            w_load = 1'b1;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (r_gap_cnt == '0) begin
          if (r_hold_full) begin
            w_load       = 1'b1;
            w_state_next = S_SHIFT;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Sclk) begin
    if (Reset) begin
      OutputL     <= 1'b0;
      OutputR     <= 1'b0;
      OutReady    <= 1'b0;
      OutFrame    <= 1'b0;
      Underrun    <= 1'b0;
      r_hold_full <= 1'b0;
      r_hold_l    <= '0;
      r_hold_r    <= '0;
      r_shift_l   <= '0;
      r_shift_r   <= '0;
      r_cnt       <= '0;
      r_gap_cnt   <= '0;
    end else begin
      Underrun <= w_underrun;

      if (w_load) begin
        OutputL   <= r_hold_l[DATA_W-1];
        OutputR   <= r_hold_r[DATA_W-1];
        r_shift_l <= r_hold_l << 1;
        r_shift_r <= r_hold_r << 1;
        r_cnt     <= CNT_W'(DATA_W - 1);
        OutReady  <= 1'b1;
        OutFrame  <= 1'b1;
      end else if (w_shift) begin
        OutputL   <= r_shift_l[DATA_W-1];
        OutputR   <= r_shift_r[DATA_W-1];
        r_shift_l <= r_shift_l << 1;
        r_shift_r <= r_shift_r << 1;
        r_cnt     <= r_cnt - CNT_W'(1);
        OutReady  <= 1'b1;
        OutFrame  <= 1'b0;
      end else begin
        OutputL  <= 1'b0;
        OutputR  <= 1'b0;
        OutReady <= 1'b0;
        OutFrame <= 1'b0;
      end

      if (w_gap_start) r_gap_cnt <= GAP_W'(GAP_CYCLES - 1);
      else if (r_state == S_GAP && r_gap_cnt != '0) r_gap_cnt <= r_gap_cnt - GAP_W'(1);

      // Load needs a full buffer and accept an empty one, so they never collide.
      if (w_load) begin
        r_hold_full <= 1'b0;
      end else if (DataValid && !r_hold_full) begin
        r_hold_l    <= DataInL;
        r_hold_r    <= DataInR;
        r_hold_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stereo_serial_tx.sv
// Bench for stereo_serial_tx: directed phases with random payloads, serial
// stream reassembled into words and compared against the words offered.
module tb_stereo_serial_tx;
  localparam int unsigned DW = 40;

  logic          Sclk = 1'b0;
  logic          Reset = 1'b1;
  logic [DW-1:0] DataInL = '0, DataInR = '0;
  logic          DataValid = 1'b0;
  logic          DataAccept, OutputL, OutputR, OutReady, OutFrame, Busy, Underrun;

  logic [DW-1:0] g_InL = '0, g_InR = '0;
  logic          g_Valid = 1'b0;
  logic          g_Accept, g_OutL, g_OutR, g_Ready, g_Frame, g_Busy, g_Underrun;

  stereo_serial_tx #(.DATA_W(DW), .GAP_CYCLES(0)) dut (
    .Sclk(Sclk), .Reset(Reset), .DataInL(DataInL), .DataInR(DataInR),
    .DataValid(DataValid), .DataAccept(DataAccept), .OutputL(OutputL),
    .OutputR(OutputR), .OutReady(OutReady), .OutFrame(OutFrame),
    .Busy(Busy), .Underrun(Underrun));

  stereo_serial_tx #(.DATA_W(DW), .GAP_CYCLES(3)) dut_gap (
    .Sclk(Sclk), .Reset(Reset), .DataInL(g_InL), .DataInR(g_InR),
    .DataValid(g_Valid), .DataAccept(g_Accept), .OutputL(g_OutL),
    .OutputR(g_OutR), .OutReady(g_Ready), .OutFrame(g_Frame),
    .Busy(g_Busy), .Underrun(g_Underrun));

  always #5 Sclk = ~Sclk;

  int cyc = 0;
  always @(posedge Sclk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Reference: words in acceptance order; stream reassembled by the monitor.
  logic [DW-1:0] exp_l[$], exp_r[$], cap_l[$], cap_r[$];
  int frame_edges[$], underrun_edges[$];
  int ready_total = 0, last_ready = 0, frame_err = 0, alt_viol = 0;
  bit alt_mode = 1'b0;
  int m_bits = 0;
  logic [DW-1:0] m_l = '0, m_r = '0;

  always @(negedge Sclk) begin
    if (Reset) begin
      m_bits = 0;
    end else begin
      if (OutFrame && !OutReady) frame_err++;
      if (OutReady) begin
        ready_total++;
        last_ready = cyc;
        if (OutFrame) begin
          frame_edges.push_back(cyc);
          if (m_bits != 0) frame_err++;
          m_bits = 0;
        end else if (m_bits == 0) begin
          frame_err++;
        end
        if (alt_mode && OutputL === OutputR) alt_viol++;
        m_l = {m_l[DW-2:0], OutputL};
        m_r = {m_r[DW-2:0], OutputR};
        m_bits++;
        if (m_bits == DW) begin
          cap_l.push_back(m_l);
          cap_r.push_back(m_r);
          m_bits = 0;
        end
      end
      if (Underrun) underrun_edges.push_back(cyc);
    end
  end

  logic [DW-1:0] g_exp_l[$], g_cap_l[$], g_cap_r[$], g_exp_r[$];
  int g_frame_edges[$], g_gaps[$];
  int g_bits = 0, g_run = 0, g_underruns = 0;
  bit g_seen = 1'b0;
  logic [DW-1:0] g_ml = '0, g_mr = '0;

  always @(negedge Sclk) begin
    if (Reset) begin
      g_bits = 0;
    end else begin
      if (g_Underrun) g_underruns++;
      if (g_Ready) begin
        if (g_seen && g_run > 0) g_gaps.push_back(g_run);
        g_run  = 0;
        g_seen = 1'b1;
        if (g_Frame) begin
          g_frame_edges.push_back(cyc);
          g_bits = 0;
        end
        g_ml = {g_ml[DW-2:0], g_OutL};
        g_mr = {g_mr[DW-2:0], g_OutR};
        g_bits++;
        if (g_bits == DW) begin
          g_cap_l.push_back(g_ml);
          g_cap_r.push_back(g_mr);
          g_bits = 0;
        end
      end else if (g_seen) begin
        g_run++;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd40();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic offer(input logic [DW-1:0] l, input logic [DW-1:0] r, output int acc);
    int n;
    n = 0;
    DataInL = l; DataInR = r; DataValid = 1'b1;
    while (n < 300 && !DataAccept) begin
      @(negedge Sclk);
      n++;
    end
    check("accept_wait", 64'(n < 300), 64'd1);
    acc = cyc + 1;
    exp_l.push_back(l);
    exp_r.push_back(r);
    @(negedge Sclk);
  endtask

  task automatic offer_g(input logic [DW-1:0] l, input logic [DW-1:0] r, output int acc);
    int n;
    n = 0;
    g_InL = l; g_InR = r; g_Valid = 1'b1;
    while (n < 300 && !g_Accept) begin
      @(negedge Sclk);
      n++;
    end
    check("gap_accept_wait", 64'(n < 300), 64'd1);
    acc = cyc + 1;
    g_exp_l.push_back(l);
    g_exp_r.push_back(r);
    @(negedge Sclk);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (n < 500 && (Busy || OutReady)) begin
      @(negedge Sclk);
      n++;
    end
    check(tag, 64'(n < 500), 64'd1);
    repeat (2) @(negedge Sclk);
  endtask

  task automatic cmp_words(input string tag, input int eb, input int cb, input int n);
    check({tag, "_count"}, 64'(cap_l.size() - cb), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (cb + i < cap_l.size()) begin
        check({tag, "_L"}, 64'(cap_l[cb+i]), 64'(exp_l[eb+i]));
        check({tag, "_R"}, 64'(cap_r[cb+i]), 64'(exp_r[eb+i]));
      end
    end
  endtask

  initial begin
    int a0, a1, a2, fb, ub, rb, eb, cb, f;
    logic [DW-1:0] w1, w2;

    // Reset state
    repeat (3) @(negedge Sclk);
    check("reset_outs", 64'({OutputL, OutputR, OutReady, OutFrame, Busy, Underrun}), 64'd0);
    Reset = 1'b0;
    @(negedge Sclk);
    check("reset_accept", 64'(DataAccept), 64'd1);
    check("reset_busy", 64'(Busy), 64'd0);

    // Single word: load one edge after accept, 40 ready cycles, underrun after
    fb = frame_edges.size(); ub = underrun_edges.size(); rb = ready_total;
    eb = exp_l.size(); cb = cap_l.size();
    offer(40'h123456789A, 40'hFEDCBA9876, a0);
    DataValid = 1'b0;
    check("single_busy", 64'(Busy), 64'd1);
    drain("single_drain");
    check("single_frames", 64'(frame_edges.size() - fb), 64'd1);
    if (frame_edges.size() > fb) check("single_frame_edge", 64'(frame_edges[fb]), 64'(a0 + 1));
    check("single_ready", 64'(ready_total - rb), 64'(DW));
    check("single_last_ready", 64'(last_ready), 64'(a0 + 40));
    check("single_underruns", 64'(underrun_edges.size() - ub), 64'd1);
    if (underrun_edges.size() > ub) check("single_underrun_edge", 64'(underrun_edges[ub]), 64'(a0 + 41));
    cmp_words("single", eb, cb, 1);

    // Back-to-back: three pairs offered continuously
    fb = frame_edges.size(); ub = underrun_edges.size(); rb = ready_total;
    eb = exp_l.size(); cb = cap_l.size();
    offer(rnd40(), rnd40(), a0);
    check("b2b_accept_low0", 64'(DataAccept), 64'd0);
    offer(rnd40(), rnd40(), a1);
    check("b2b_accept_low1", 64'(DataAccept), 64'd0);
    offer(rnd40(), rnd40(), a2);
    check("b2b_accept_low2", 64'(DataAccept), 64'd0);
    DataValid = 1'b0;
    drain("b2b_drain");
    check("b2b_frames", 64'(frame_edges.size() - fb), 64'd3);
    if (frame_edges.size() >= fb + 3) begin
      check("b2b_frame0", 64'(frame_edges[fb]), 64'(a0 + 1));
      check("b2b_frame1", 64'(frame_edges[fb+1]), 64'(a0 + 41));
      check("b2b_frame2", 64'(frame_edges[fb+2]), 64'(a0 + 81));
    end
    check("b2b_ready", 64'(ready_total - rb), 64'd120);
    check("b2b_last_ready", 64'(last_ready), 64'(a0 + 120));
    check("b2b_underruns", 64'(underrun_edges.size() - ub), 64'd1);
    if (underrun_edges.size() > ub) check("b2b_underrun_edge", 64'(underrun_edges[ub]), 64'(a0 + 121));
    cmp_words("b2b", eb, cb, 3);

    // Backpressure with random offer spacing
    eb = exp_l.size(); cb = cap_l.size();
    for (int i = 0; i < 8; i++) begin
      offer(rnd40(), rnd40(), a0);
      if ($urandom_range(0, 2) == 0) begin
        DataValid = 1'b0;
        repeat ($urandom_range(1, 50)) @(negedge Sclk);
      end
    end
    DataValid = 1'b0;
    drain("bp_drain");
    cmp_words("bp", eb, cb, 8);

    // Alternating patterns: channels complementary on every bit
    eb = exp_l.size(); cb = cap_l.size();
    alt_mode = 1'b1;
    offer(40'hAAAAAAAAAA, 40'h5555555555, a0);
    DataValid = 1'b0;
    drain("alt_drain");
    alt_mode = 1'b0;
    check("alt_complement", 64'(alt_viol), 64'd0);
    cmp_words("alt", eb, cb, 1);

    // Reset on bit 17 with a second word held
    fb = frame_edges.size(); cb = cap_l.size();
    w1 = rnd40(); w2 = rnd40();
    offer(w1, w2, a0);
    offer(w2, w1, a1);
    DataValid = 1'b0;
    begin
      int n;
      n = 0;
      while (n < 100 && frame_edges.size() == fb) begin
        @(negedge Sclk);
        n++;
      end
      check("rst_frame_wait", 64'(n < 100), 64'd1);
    end
    f = (frame_edges.size() > fb) ? frame_edges[fb] : cyc;
    while (cyc < f + 17) @(negedge Sclk);
    check("rst_held_busy", 64'({Busy, DataAccept, OutReady}), 64'b101);
    Reset = 1'b1;
    @(negedge Sclk);
    check("rst_outs", 64'({OutputL, OutputR, OutReady, OutFrame, Busy, Underrun}), 64'd0);
    check("rst_accept", 64'(DataAccept), 64'd1);
    Reset = 1'b0;
    rb = ready_total;
    repeat (60) @(negedge Sclk);
    check("rst_no_ready", 64'(ready_total - rb), 64'd0);
    check("rst_no_words", 64'(cap_l.size() - cb), 64'd0);
    check("rst_idle_busy", 64'(Busy), 64'd0);
    check("frame_errors", 64'(frame_err), 64'd0);

    // GAP_CYCLES=3 instance: two words, three idle cycles between them
    offer_g(rnd40(), rnd40(), a0);
    offer_g(rnd40(), rnd40(), a1);
    g_Valid = 1'b0;
    begin
      int n;
      n = 0;
      while (n < 300 && (g_Busy || g_Ready)) begin
        @(negedge Sclk);
        n++;
      end
      check("gap_drain", 64'(n < 300), 64'd1);
      repeat (2) @(negedge Sclk);
    end
    check("gap_frames", 64'(g_frame_edges.size()), 64'd2);
    if (g_frame_edges.size() == 2) begin
      check("gap_first_frame", 64'(g_frame_edges[0]), 64'(a0 + 1));
      check("gap_frame_spacing", 64'(g_frame_edges[1] - g_frame_edges[0]), 64'd43);
    end
    check("gap_runs", 64'(g_gaps.size()), 64'd1);
    if (g_gaps.size() == 1) check("gap_len", 64'(g_gaps[0]), 64'd3);
    check("gap_underruns", 64'(g_underruns), 64'd1);
    check("gap_words", 64'(g_cap_l.size()), 64'd2);
    for (int i = 0; i < 2; i++) begin
      if (i < g_cap_l.size()) begin
        check("gap_word_L", 64'(g_cap_l[i]), 64'(g_exp_l[i]));
        check("gap_word_R", 64'(g_cap_r[i]), 64'(g_exp_r[i]));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
